game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Central game-flow controller for the Flappy Bird datapath. It sequences the bird and the
//  NUM_PIPES pipe engines: it launches pipes in a staggered order and latches game-over on
//  collision. It also clears the score on each new round and enforces a restart lockout.
//  Sits between the top-level KEY inputs, the collision/score block, and the pipes/bird/RGB logic.
// PARAMETERS
//  NUM_PIPES  3           number of pipe engines sequenced (>=1)
//  LAUNCH_X   10'd213     pipe i launches when pipe i-1 x0 equals this value
//  OVER_HOLD  25_000_000  cycles in OVER before a restart is accepted (0.5 s at 50 MHz)
// PORTS
//  clk         in   1             system clock (50 MHz)
//  reset       in   1             asynchronous, active-low reset (0 = reset asserted)
//  start_btn   in   1             game start request, active-high level, already synchronized
//  bird_btn    in   1             bird-only start request, active-high level, already synchronized
//  collision   in   1             active-high collision flag from the collision/score block
//  pipe_x0     in   10*NUM_PIPES  packed left-edge x of each pipe; pipe i = [10*i+9:10*i]
//  pipe_start  out  NUM_PIPES     per-pipe run enable, sticky while RUN
//  bird_start  out  1             bird physics enable
//  game_over   out  1             high while in OVER
//  clear_scr   out  1             RGB logic paints white while high
//  score_clr   out  1             one-cycle pulse that clears the score counter
//  state       out  2             FSM state: IDLE=0, BIRD=1, RUN=2, OVER=3
// BEHAVIOUR
//  - All outputs are registered. Reset (reset==0) forces, asynchronously:
//    state=IDLE, pipe_start=0, bird_start=0, game_over=0, clear_scr=1, score_clr=0,
//    hold counter=0, edge registers=0.
//  - Edge detect: start_rise = start_btn & ~start_q; bird_rise likewise. start_q/bird_q
//    register the inputs every cycle. Levels never re-trigger; only rising edges act.
//  - IDLE: clear_scr=1.
//      start_rise -> RUN.
//      else bird_rise -> BIRD.
//      Both on the same cycle -> RUN.
//  - BIRD: bird_start=1, clear_scr=0, pipe_start=0.
//      start_rise -> RUN.
//      collision is ignored, because no pipes are running.
//  - RUN entry, 1 cycle after the start_rise sample edge:
//      score_clr=1 for exactly that one cycle;
//      pipe_start[0]=1; bird_start=1; clear_scr=0; all higher pipe_start bits=0.
//  - RUN launch: pipe_start[i] (i>=1) sets on the cycle after
//    pipe_start[i-1]==1 && pipe_x0[i-1]==LAUNCH_X. Once set, it stays set until the round
//    leaves RUN. Exact-equality compare only.
//  - RUN exit: collision==1 sampled -> OVER on the next edge.
//    Collision has priority over any start_rise or launch condition on the same cycle.
//  - OVER: game_over=1, clear_scr=1, pipe_start=0, bird_start=0.
//      The hold counter (ceil(log2(OVER_HOLD+1)) bits) clears on entry and increments each
//      cycle, saturating at OVER_HOLD.
//      start_rise while counter<OVER_HOLD is discarded; it does not queue.
//      start_rise once counter==OVER_HOLD -> RUN, with the full RUN-entry actions
//      (score_clr pulse included).
//      bird_rise in OVER is ignored.
//  - collision with no state change (IDLE/BIRD/OVER) has no effect.
//  - Reset mid-round returns to IDLE immediately. No partial pipe state is kept.
// TESTING  (bench uses OVER_HOLD=8, NUM_PIPES=3, LAUNCH_X=213)
//  1. Release reset, hold start_btn=1 for 5 cycles -> exactly one score_clr pulse;
//     state=2; pipe_start=3'b001.
//  2. In RUN, drive pipe_x0[0]=213 for 1 cycle -> pipe_start=3'b011 next cycle.
//     Then drive pipe_x0[1]=213 -> 3'b111. Drive pipe_x0[0]=213 again -> no change.
//  3. In RUN, assert collision together with start_rise -> state=3, game_over=1,
//     pipe_start=0, bird_start=0, clear_scr=1, no score_clr.
//  4. In OVER, pulse start_btn at cycle 3 after entry -> stays OVER.
//     Pulse again at cycle 10 -> RUN plus a score_clr pulse.
//  5. From IDLE, pulse bird_btn -> state=1, bird_start=1, pipe_start=0.
//     Assert collision -> stays BIRD. Pulse start_btn -> RUN.
//  6. In RUN with pipe_start=3'b111, drop reset mid-cycle -> outputs take reset values
//     before the next clk edge. Raise reset -> state=0.

Source files
------------

// File: rtl/game_sequencer.sv
// Flappy Bird game-flow controller: round sequencing, staggered pipe
// launch, game-over latch, score clear and restart lockout.
module game_sequencer #(
  parameter int         NUM_PIPES = 3,
  parameter logic [9:0] LAUNCH_X  = 10'd213,
  parameter int         OVER_HOLD = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_btn,
  input  logic                    bird_btn,
  input  logic                    collision,
  input  logic [10*NUM_PIPES-1:0] pipe_x0,
  output logic [NUM_PIPES-1:0]    pipe_start,
  output logic                    bird_start,
  output logic                    game_over,
  output logic                    clear_scr,
  output logic                    score_clr,
  output logic [1:0]              state
);

  localparam int CW =
    (OVER_HOLD < 1) ? 1 : $clog2(OVER_HOLD + 1);
  localparam logic [CW-1:0] HOLD = CW'(OVER_HOLD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIRD = 2'd1,
    RUN  = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t               cur, nxt;
  logic [CW-1:0]        cnt, nxt_cnt;
  logic                 start_q, bird_q;
  logic                 start_rise, bird_rise;
  logic [NUM_PIPES-1:0] nxt_pipe;
  logic                 nxt_bird, nxt_over;
  logic                 nxt_clear, nxt_clr;

  assign start_rise = start_btn & ~start_q;
  assign bird_rise  = bird_btn & ~bird_q;
  assign state      = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur        <= IDLE;
      cnt        <= '0;
      start_q    <= 1'b0;
      bird_q     <= 1'b0;
      pipe_start <= '0;
      bird_start <= 1'b0;
      game_over  <= 1'b0;
      clear_scr  <= 1'b1;
      score_clr  <= 1'b0;
    end else begin
      cur        <= nxt;
      cnt        <= nxt_cnt;
      start_q    <= start_btn;
      bird_q     <= bird_btn;
      pipe_start <= nxt_pipe;
      bird_start <= nxt_bird;
      game_over  <= nxt_over;
      clear_scr  <= nxt_clear;
      score_clr  <= nxt_clr;
    end
  end

  always_comb begin
    nxt       = cur;
    nxt_cnt   = cnt;
    nxt_pipe  = pipe_start;
    nxt_bird  = bird_start;
    nxt_over  = game_over;
    nxt_clear = clear_scr;
    nxt_clr   = 1'b0;
    unique case (cur)
      IDLE: begin
        nxt_pipe  = '0;
        nxt_bird  = 1'b0;
        nxt_over  = 1'b0;
        nxt_clear = 1'b1;
        if (bird_rise && !start_rise) begin
          nxt       = BIRD;
          nxt_bird  = 1'b1;
          nxt_clear = 1'b0;
        end
      end
      BIRD: begin
        nxt_pipe  = '0;
        nxt_bird  = 1'b1;
        nxt_over  = 1'b0;
        nxt_clear = 1'b0;
      end
      RUN: begin
        if (collision) begin
          nxt       = OVER;
          nxt_cnt   = '0;
          nxt_pipe  = '0;
          nxt_bird  = 1'b0;
          nxt_over  = 1'b1;
          nxt_clear = 1'b1;
        end else begin
          for (int i = 1; i < NUM_PIPES; i++) begin
            if (pipe_start[i-1] &&
                pipe_x0[10*(i-1) +: 10] == LAUNCH_X)
              nxt_pipe[i] = 1'b1;
          end
        end
      end
      OVER: begin
        nxt_pipe  = '0;
        nxt_bird  = 1'b0;
        nxt_over  = 1'b1;
        nxt_clear = 1'b1;
        if (cnt < HOLD) nxt_cnt = cnt + 1'b1;
      end
      default: nxt = IDLE;
    endcase
    // Any accepted start enters RUN with the same entry actions
    if (start_rise &&
        (cur == IDLE || cur == BIRD ||
         (cur == OVER && cnt == HOLD))) begin
      nxt       = RUN;
      nxt_clr   = 1'b1;
      nxt_pipe  = NUM_PIPES'(1);
      nxt_bird  = 1'b1;
      nxt_over  = 1'b0;
      nxt_clear = 1'b0;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with OVER_HOLD=8,
// NUM_PIPES=3, LAUNCH_X=213.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_btn, bird_btn, collision;
  logic [29:0] pipe_x0;
  logic [2:0]  pipe_start;
  logic        bird_start, game_over, clear_scr, score_clr;
  logic [1:0]  state;
  int checks = 0;
  int errors = 0;

  game_sequencer #(
    .NUM_PIPES(3),
    .LAUNCH_X(10'd213),
    .OVER_HOLD(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_btn(start_btn),
    .bird_btn(bird_btn),
    .collision(collision),
    .pipe_x0(pipe_x0),
    .pipe_start(pipe_start),
    .bird_start(bird_start),
    .game_over(game_over),
    .clear_scr(clear_scr),
    .score_clr(score_clr),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0; start_btn = 1'b0; bird_btn = 1'b0;
    collision = 1'b0; pipe_x0 = '0;
    cyc(2);
    checks++;
    if ({state, pipe_start, bird_start, game_over,
         clear_scr, score_clr} !== 9'b00_000_0010) begin
      errors++;
      $display("FAIL reset_outputs got %b required %b",
        {state, pipe_start, bird_start, game_over,
         clear_scr, score_clr}, 9'b00_000_0010);
    end
    reset = 1'b1;
    cyc(1);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL idle_after_release got %0d required 0", state);
    end
  endtask

  task automatic test_start_level;
    int pulses = 0;
    start_btn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (score_clr === 1'b1) pulses++;
    end
    start_btn = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL score_clr_pulses got %0d required 1", pulses);
    end
    checks++;
    if ({state, pipe_start, bird_start, clear_scr}
        !== 7'b10_001_1_0) begin
      errors++;
      $display("FAIL run_entry got %b required %b",
        {state, pipe_start, bird_start, clear_scr}, 7'b10_001_1_0);
    end
  endtask

  task automatic test_launch;
    pipe_x0[9:0] = 10'd213;
    cyc(1);
    pipe_x0[9:0] = 10'd0;
    checks++;
    if (pipe_start !== 3'b011) begin
      errors++;
      $display("FAIL launch1 got %b required 011", pipe_start);
    end
    pipe_x0[19:10] = 10'd212;
    cyc(1);
    checks++;
    if (pipe_start !== 3'b011) begin
      errors++;
      $display("FAIL near_miss got %b required 011", pipe_start);
    end
    pipe_x0[19:10] = 10'd213;
    cyc(1);
    pipe_x0[19:10] = 10'd0;
    checks++;
    if (pipe_start !== 3'b111) begin
      errors++;
      $display("FAIL launch2 got %b required 111", pipe_start);
    end
    pipe_x0[9:0] = 10'd213;
    cyc(2);
    pipe_x0 = '0;
    checks++;
    if (pipe_start !== 3'b111) begin
      errors++;
      $display("FAIL sticky got %b required 111", pipe_start);
    end
  endtask

  task automatic test_collision;
    collision = 1'b1; start_btn = 1'b1;
    cyc(1);
    collision = 1'b0; start_btn = 1'b0;
    checks++;
    if ({state, game_over, pipe_start, bird_start,
         clear_scr, score_clr} !== 9'b11_1_000_0_1_0) begin
      errors++;
      $display("FAIL over_entry got %b required %b",
        {state, game_over, pipe_start, bird_start,
         clear_scr, score_clr}, 9'b11_1_000_0_1_0);
    end
  endtask

  task automatic test_lockout;
    // now at hold count 0
    cyc(2);
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    checks++;
    if (state !== 2'd3 || score_clr !== 1'b0) begin
      errors++;
      $display("FAIL early_start got st=%0d sc=%b required 3/0",
        state, score_clr);
    end
    bird_btn = 1'b1;
    cyc(1);
    bird_btn = 1'b0;
    checks++;
    if (state !== 2'd3) begin
      errors++;
      $display("FAIL bird_in_over got %0d required 3", state);
    end
    cyc(2);
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    checks++;
    if (state !== 2'd3) begin
      errors++;
      $display("FAIL hold_minus1 got %0d required 3", state);
    end
    cyc(1);
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    checks++;
    if ({state, score_clr, game_over, pipe_start}
        !== 7'b10_1_0_001) begin
      errors++;
      $display("FAIL restart got %b required %b",
        {state, score_clr, game_over, pipe_start}, 7'b10_1_0_001);
    end
    cyc(1);
    checks++;
    if (score_clr !== 1'b0) begin
      errors++;
      $display("FAIL restart_pulse_len got %b required 0", score_clr);
    end
  endtask

  task automatic test_bird;
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    bird_btn = 1'b1;
    cyc(1);
    checks++;
    if ({state, bird_start, pipe_start, clear_scr}
        !== 7'b01_1_000_0) begin
      errors++;
      $display("FAIL bird_entry got %b required %b",
        {state, bird_start, pipe_start, clear_scr}, 7'b01_1_000_0);
    end
    collision = 1'b1;
    cyc(2);
    collision = 1'b0; bird_btn = 1'b0;
    checks++;
    if (state !== 2'd1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL bird_collision got st=%0d go=%b required 1/0",
        state, game_over);
    end
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    checks++;
    if ({state, score_clr, pipe_start} !== 6'b10_1_001) begin
      errors++;
      $display("FAIL bird_to_run got %b required 101001",
        {state, score_clr, pipe_start});
    end
  endtask

  task automatic test_both_buttons;
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    start_btn = 1'b1; bird_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0; bird_btn = 1'b0;
    checks++;
    if (state !== 2'd2 || score_clr !== 1'b1) begin
      errors++;
      $display("FAIL both_buttons got st=%0d sc=%b required 2/1",
        state, score_clr);
    end
  endtask

  task automatic test_async_reset;
    pipe_x0[9:0] = 10'd213;
    cyc(1);
    pipe_x0 = {10'd0, 10'd213, 10'd0};
    cyc(1);
    pipe_x0 = '0;
    checks++;
    if (pipe_start !== 3'b111) begin
      errors++;
      $display("FAIL pre_reset got %b required 111", pipe_start);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({state, pipe_start, bird_start, game_over,
         clear_scr, score_clr} !== 9'b00_000_0010) begin
      errors++;
      $display("FAIL async_reset got %b required %b",
        {state, pipe_start, bird_start, game_over,
         clear_scr, score_clr}, 9'b00_000_0010);
    end
    cyc(2);
    reset = 1'b1;
    cyc(1);
    checks++;
    if (state !== 2'd0 || pipe_start !== 3'b000) begin
      errors++;
      $display("FAIL post_reset got st=%0d ps=%b required 0/000",
        state, pipe_start);
    end
  endtask

  initial begin
    test_reset();
    test_start_level();
    test_launch();
    test_collision();
    test_lockout();
    test_bird();
    test_both_buttons();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
